mem_bus_adapter: RTL
====================

// Module: mem_bus_adapter
// PURPOSE
//   Sits directly downstream of the core datapath's memory interface. Takes one
//   byte/half/word load or store request at a time and turns it into a
//   word-aligned bus transaction with byte enables and a req/gnt/rvalid handshake.
//   Returns load data right-justified and zero-extended; the datapath applies
//   sign extension itself. Flags misaligned, illegal-size and timed-out accesses.
// PARAMETERS
//   TIMEOUT_CYCLES  256  cycles in REQ+WAIT before the access is aborted with error
// PORTS
//   clk_i          in   1   clock
//   reset_i        in   1   synchronous, active-high reset
//   req_valid_i    in   1   core request strobe; sampled only in IDLE
//   req_we_i       in   1   1 = store, 0 = load
//   req_addr_i     in   32  byte address
//   req_size_i     in   2   0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_wdata_i    in   32  store data, right-justified
//   busy_o         out  1   state != IDLE
//   resp_valid_o   out  1   1-cycle pulse: access complete
//   resp_rdata_o   out  32  load data, zero-extended; valid with resp_valid_o
//   resp_error_o   out  1   qualifies resp_valid_o: misaligned, illegal size or timeout
//   bus_req_o      out  1   bus request; held until bus_gnt_i
//   bus_we_o       out  1   bus write
//   bus_addr_o     out  32  {addr[31:2], 2'b00}
//   bus_be_o       out  4   byte enables
//   bus_wdata_o    out  32  lane-replicated store data
//   bus_gnt_i      in   1   request accepted this cycle
//   bus_rvalid_i   in   1   read data valid
//   bus_rdata_i    in   32  read data, full word
// BEHAVIOUR
//   Reset: state = IDLE. All outputs are 0. Timeout counter is 0.
//   State machine: IDLE -> REQ -> (WAIT, reads only) -> RESP -> IDLE. ERR -> IDLE.
//   IDLE: when req_valid_i, latch addr, size, we and wdata.
//     - Size 3, half with addr[0] = 1, or word with addr[1:0] != 0 -> ERR.
//       No bus activity.
//     - Otherwise -> REQ.
//   REQ: bus_req_o = 1. bus_addr_o, bus_be_o, bus_we_o and bus_wdata_o come
//     from registers and stay stable until grant.
//     - On bus_gnt_i: a store goes to RESP; a load goes to WAIT.
//     - bus_req_o drops in the cycle after the grant.
//   WAIT: on bus_rvalid_i, shift rdata right by 8*addr[1:0]. Mask to 8, 16 or
//     32 bits per size. Register the result into resp_rdata_o, then -> RESP.
//   RESP: resp_valid_o = 1 for exactly one cycle, then -> IDLE.
//   ERR: resp_valid_o = 1 and resp_error_o = 1 for one cycle. resp_rdata_o = 0.
//     Then -> IDLE.
//   Byte enables: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << {addr[1],1'b0};
//     word = 4'b1111.
//   Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
//   Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT.
//     On reaching TIMEOUT_CYCLES-1 without gnt/rvalid: drop bus_req_o, -> ERR.
//   Latency: load with same-cycle grant and next-cycle rvalid is accept@T,
//     REQ@T+1, WAIT@T+2, resp_valid_o@T+3. Store with same-cycle grant is
//     resp_valid_o@T+2. Error is resp_valid_o@T+1.
//   busy_o is high from T+1 until the cycle after resp_valid_o.
//     req_valid_i is ignored while busy.
//   bus_rvalid_i outside WAIT is ignored, including a stray rvalid after reset or
//     timeout. bus_gnt_i outside REQ is ignored.
//   Reset mid-access: return to IDLE next edge. bus_req_o = 0 and no response is
//     emitted. The pending bus response is discarded.
//   resp_rdata_o holds its last value except in ERR (forced 0).
// TESTING
//   LB addr 0x103, bus_rdata 0xAABBCCDD, gnt and rvalid immediate
//     -> be = 4'b1000, resp_rdata = 0x000000AA at T+3.
//   SH addr 0x102, wdata 0x1234ABCD -> be = 4'b1100, bus_wdata = 0xABCDABCD,
//     bus_addr = 0x100, resp_valid at T+2.
//   LW addr 0x101 -> resp_error = 1 at T+1, bus_req_o never asserted.
//     Size 3 gives the same result.
//   Grant withheld 10 cycles -> bus_req/addr/be stable throughout,
//     single resp_valid after rvalid.
//   No gnt for TIMEOUT_CYCLES -> error response, bus_req dropped.
//     A later stray rvalid is ignored.
//   reset_i during WAIT, then rvalid -> no resp_valid. A new LW completes normally.

Source files
------------

// File: rtl/mem_bus_adapter.sv
// rtl/mem_bus_adapter.sv - single-access load/store to word-aligned req/gnt/rvalid bus adapter
// Byte/half/word requests become byte-enabled word transactions; loads return zero-extended data.
module mem_bus_adapter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        busy_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          we_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic [29:0]   waddr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;

    logic          req_bad;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [31:0]   rd_shifted;
    logic [31:0]   rd_lane;

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        req_bad = (req_size_i == 2'd3)
               || (req_size_i == 2'd1 && req_addr_i[0])
               || (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);
        case (req_size_i)
            2'd0: begin
                be_n    = 4'b0001 << req_addr_i[1:0];
                wdata_n = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                be_n    = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_n = {2{req_wdata_i[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = req_wdata_i;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then zero everything above the access size.
    always_comb begin
        rd_shifted = bus_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rd_lane = {24'b0, rd_shifted[7:0]};
            2'd1:    rd_lane = {16'b0, rd_shifted[15:0]};
            default: rd_lane = rd_shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_next = req_bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_next = we_q ? S_RESP : S_WAIT;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_next = S_RESP;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt <= '0;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            waddr_q <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == S_IDLE) begin
                tmo_cnt <= '0;
            end else if (state == S_REQ || state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == S_IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                off_q   <= req_addr_i[1:0];
                size_q  <= req_size_i;
                waddr_q <= req_addr_i[31:2];
                be_q    <= be_n;
                wdata_q <= wdata_n;
            end
            if (state_next == S_ERR) begin
                rdata_q <= '0;
            end else if (state == S_WAIT && bus_rvalid_i) begin
                rdata_q <= rd_lane;
            end
        end
    end

    assign busy_o       = (state != S_IDLE);
    assign resp_valid_o = (state == S_RESP) || (state == S_ERR);
    assign resp_error_o = (state == S_ERR);
    assign resp_rdata_o = rdata_q;
    assign bus_req_o    = (state == S_REQ);
    assign bus_we_o     = (state == S_REQ) && we_q;
    assign bus_be_o     = (state == S_REQ) ? be_q : 4'b0000;
    assign bus_addr_o   = {waddr_q, 2'b00};
    assign bus_wdata_o  = wdata_q;

endmodule
